// File: rtl/rvvi_seq_pkg.sv
// Shared types and width helpers for the RVVI retirement sequencer.
// Contents:
//   idx_w()        - index width for a count, never narrower than one bit
//   cnt_w()        - width able to hold 0..n inclusive
//   seq_state_e    - arbitration state (IDLE / OWN)
//   rvvi_event_t   - one sequenced event laid out for the default configuration
//                    (2 harts, 64-bit PC and order, 32-bit instruction, burst 4)
package rvvi_seq_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int NHART_DEF     = 2;
  localparam int XLEN_DEF      = 64;
  localparam int ILEN_DEF      = 32;
  localparam int MAX_BURST_DEF = 4;
  localparam int ORDER_W_DEF   = 64;
  localparam int HART_W_DEF    = idx_w(NHART_DEF);
  localparam int ISSUE_W_DEF   = idx_w(MAX_BURST_DEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [HART_W_DEF-1:0]  hart;
    logic [ISSUE_W_DEF-1:0] issue;
    logic [ORDER_W_DEF-1:0] order;
    logic                   hart_switch;
    logic [XLEN_DEF-1:0]    pc;
    logic [ILEN_DEF-1:0]    insn;
    logic                   trap;
  } rvvi_event_t;

endpackage

// File: rtl/rvvi_rr_arbiter.sv
// Combinational rotate-priority picker.
// Ports:
//   req   [N]      - request vector
//   start [IDX_W]  - index with highest priority (must be < N)
//   gnt   [N]      - one-hot grant of the first request at or after start
//   idx   [IDX_W]  - encoded index of the grant
//   any            - at least one request present
module rvvi_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(start) + k) % N;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// Merges per-hart retirement/trap events into one ordered RVVI event stream.
// Burst-limited round-robin: a hart keeps the grant for up to MAX_BURST
// back-to-back events, then the pick rotates from the hart after it.
// Ports:
//   in_valid/in_ready [NHART]        - per-hart handshake (ready only to the granted hart)
//   in_pc/in_insn/in_trap            - per-hart payload, hart h at [h*W +: W]
//   order_load/order_init            - preset of the global order counter
//   out_valid/out_ready              - single registered output stage
//   out_hart/out_issue/out_order     - source hart, slot within burst, global order
//   out_hart_switch                  - first event after a hart change or after reset
//   out_pc/out_insn/out_trap         - event payload
module rvvi_retire_sequencer
  import rvvi_seq_pkg::*;
#(
  parameter int NHART     = 2,
  parameter int XLEN      = 64,
  parameter int ILEN      = 32,
  parameter int MAX_BURST = 4,
  parameter int ORDER_W   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NHART-1:0]              in_valid,
  output logic [NHART-1:0]              in_ready,
  input  logic [NHART*XLEN-1:0]         in_pc,
  input  logic [NHART*ILEN-1:0]         in_insn,
  input  logic [NHART-1:0]              in_trap,
  input  logic                          order_load,
  input  logic [ORDER_W-1:0]            order_init,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [idx_w(NHART)-1:0]       out_hart,
  output logic [idx_w(MAX_BURST)-1:0]   out_issue,
  output logic [ORDER_W-1:0]            out_order,
  output logic                          out_hart_switch,
  output logic [XLEN-1:0]               out_pc,
  output logic [ILEN-1:0]               out_insn,
  output logic                          out_trap
);

  localparam int HART_W  = idx_w(NHART);
  localparam int ISSUE_W = idx_w(MAX_BURST);
  localparam int BURST_W = cnt_w(MAX_BURST);
  localparam logic [HART_W-1:0] LAST_RST = HART_W'(NHART - 1);

  typedef struct packed {
    logic [HART_W-1:0]  hart;
    logic [ISSUE_W-1:0] issue;
    logic [ORDER_W-1:0] order;
    logic               hart_switch;
    logic [XLEN-1:0]    pc;
    logic [ILEN-1:0]    insn;
    logic               trap;
  } event_t;

  seq_state_e          state_q, state_d;
  // last_q is the most recently granted hart: the owner while in OWN, and
  // (once prev_valid_q is set) also the previously emitted hart.
  logic [HART_W-1:0]   last_q, last_d;
  logic                prev_valid_q, prev_valid_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [ORDER_W-1:0]  order_q, order_d;
  logic                out_valid_q, out_valid_d;
  event_t              ev_q, ev_d;

  logic                slot_free;
  logic                keep_owner;
  logic                xfer;
  logic [HART_W-1:0]   rr_start;
  logic [NHART-1:0]    rr_gnt;
  logic [HART_W-1:0]   rr_idx;
  logic                rr_any;
  logic [NHART-1:0]    grant;
  logic [HART_W-1:0]   sel;
  logic [ORDER_W-1:0]  ev_order;

  // Rotation always restarts after the last granted hart; in IDLE that is the
  // previous owner, in OWN it is the current owner whose burst is ending.
  assign rr_start = (last_q == LAST_RST) ? '0 : last_q + HART_W'(1);

  rvvi_rr_arbiter #(
    .N     (NHART),
    .IDX_W (HART_W)
  ) u_rr (
    .req   (in_valid),
    .start (rr_start),
    .gnt   (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign slot_free  = !out_valid_q || out_ready;
  assign keep_owner = (state_q == ST_OWN) && in_valid[last_q] &&
                      (burst_q < BURST_W'(MAX_BURST));
  assign grant      = keep_owner ? (NHART'(1) << last_q) : rr_gnt;
  assign in_ready   = slot_free ? grant : '0;
  assign xfer       = slot_free && (keep_owner || rr_any);
  assign sel        = keep_owner ? last_q : rr_idx;
  // A load coinciding with a transfer numbers that very event.
  assign ev_order   = order_load ? order_init : order_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    prev_valid_d = prev_valid_q;
    burst_d      = burst_q;
    order_d      = order_q;
    out_valid_d  = out_valid_q;
    ev_d         = ev_q;

    if (xfer) begin
      state_d          = ST_OWN;
      last_d           = sel;
      prev_valid_d     = 1'b1;
      burst_d          = keep_owner ? burst_q + BURST_W'(1) : BURST_W'(1);
      order_d          = ev_order + ORDER_W'(1);
      out_valid_d      = 1'b1;
      ev_d.hart        = sel;
      ev_d.issue       = keep_owner ? ISSUE_W'(burst_q) : '0;
      ev_d.order       = ev_order;
      ev_d.hart_switch = !prev_valid_q || (sel != last_q);
      ev_d.pc          = in_pc[int'(sel)*XLEN +: XLEN];
      ev_d.insn        = in_insn[int'(sel)*ILEN +: ILEN];
      ev_d.trap        = in_trap[sel];
    end else begin
      // A load without a transfer presets the counter even while stalled.
      if (order_load) begin
        order_d = order_init;
      end
      // Free slot with nothing granted means no hart is requesting.
      if (slot_free) begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
        burst_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= LAST_RST;
      prev_valid_q <= 1'b0;
      burst_q      <= '0;
      order_q      <= '0;
      out_valid_q  <= 1'b0;
      ev_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      prev_valid_q <= prev_valid_d;
      burst_q      <= burst_d;
      order_q      <= order_d;
      out_valid_q  <= out_valid_d;
      ev_q         <= ev_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_hart        = ev_q.hart;
  assign out_issue       = ev_q.issue;
  assign out_order       = ev_q.order;
  assign out_hart_switch = ev_q.hart_switch;
  assign out_pc          = ev_q.pc;
  assign out_insn        = ev_q.insn;
  assign out_trap        = ev_q.trap;

endmodule

// File: tb/tb_rvvi_retire_sequencer.sv
// Bench for rvvi_retire_sequencer (2 harts, burst 4, 64-bit order).
// Each hart producer holds a payload derived from (hart, event number) and
// advances after a handshake; each scenario pushes the events it expects and
// a negedge monitor pops and compares them as the output is accepted.
module tb_rvvi_retire_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_valid;
  logic [1:0]   in_ready;
  logic [127:0] in_pc;
  logic [63:0]  in_insn;
  logic [1:0]   in_trap;
  logic         order_load;
  logic [63:0]  order_init;
  logic         out_valid;
  logic         out_ready;
  logic [0:0]   out_hart;
  logic [1:0]   out_issue;
  logic [63:0]  out_order;
  logic         out_hart_switch;
  logic [63:0]  out_pc;
  logic [31:0]  out_insn;
  logic         out_trap;

  rvvi_retire_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .in_insn         (in_insn),
    .in_trap         (in_trap),
    .order_load      (order_load),
    .order_init      (order_init),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_hart        (out_hart),
    .out_issue       (out_issue),
    .out_order       (out_order),
    .out_hart_switch (out_hart_switch),
    .out_pc          (out_pc),
    .out_insn        (out_insn),
    .out_trap        (out_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          hart;
    int          issue;
    logic [63:0] order;
    bit          sw;
    logic [63:0] pc;
    logic [31:0] insn;
    bit          trap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   seq[2];
  int   exp_seq[2];
  logic [1:0] valid_en;
  logic [1:0] hs_q;

  function automatic logic [63:0] pc_of(input int h, input int n);
    return 64'h8000_0000 + 64'(h) * 64'h10_0000 + 64'(n) * 64'd4;
  endfunction

  function automatic logic [31:0] insn_of(input int h, input int n);
    return 32'h13 + 32'(h) * 32'h100 + 32'(n) * 32'h1_0000;
  endfunction

  function automatic bit trap_of(input int h, input int n);
    return ((n + h) % 3) == 2;
  endfunction

  task automatic apply_inputs();
    for (int h = 0; h < 2; h++) begin
      in_valid[h]          = valid_en[h];
      in_pc[h*64 +: 64]    = pc_of(h, seq[h]);
      in_insn[h*32 +: 32]  = insn_of(h, seq[h]);
      in_trap[h]           = trap_of(h, seq[h]);
    end
  endtask

  task automatic set_valid(input logic [1:0] v);
    valid_en = v;
    apply_inputs();
  endtask

  // Handshakes are captured on the negedge, where inputs and ready are settled.
  always @(negedge clk) hs_q = in_valid & in_ready;

  task automatic step();
    @(posedge clk);
    #1;
    for (int h = 0; h < 2; h++) if (hs_q[h]) seq[h]++;
    apply_inputs();
  endtask

  task automatic push_exp(input int h, input int issue, input logic [63:0] order, input bit sw);
    exp_t e;
    e.hart  = h;
    e.issue = issue;
    e.order = order;
    e.sw    = sw;
    e.pc    = pc_of(h, exp_seq[h]);
    e.insn  = insn_of(h, exp_seq[h]);
    e.trap  = trap_of(h, exp_seq[h]);
    exp_seq[h]++;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got hart=%0d order=%0d, want no event", out_hart, out_order);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_hart !== 1'(e.hart) || out_issue !== 2'(e.issue) || out_order !== e.order ||
            out_hart_switch !== e.sw || out_pc !== e.pc || out_insn !== e.insn || out_trap !== e.trap) begin
          bad++;
          $display("FAIL event: got hart=%0d issue=%0d order=%0d sw=%0b pc=%h insn=%h trap=%0b, want hart=%0d issue=%0d order=%0d sw=%0b pc=%h insn=%h trap=%0b",
                   out_hart, out_issue, out_order, out_hart_switch, out_pc, out_insn, out_trap,
                   e.hart, e.issue, e.order, e.sw, e.pc, e.insn, e.trap);
        end else begin
          $display("event ok: hart=%0d issue=%0d order=%0d sw=%0b trap=%0b", out_hart, out_issue, out_order, out_hart_switch, out_trap);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d events still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
    $display("%s: done", name);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_valid(2'b00);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_order !== 64'd0 || out_pc !== 64'd0 || out_hart_switch !== 1'b0 || in_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: got valid=%0b order=%0d pc=%h sw=%0b ready=%b, want 0 0 0 0 00",
               out_valid, out_order, out_pc, out_hart_switch, in_ready);
    end else $display("reset_state ok");
  endtask

  task automatic test_single_hart();
    push_exp(0, 0, 64'd0, 1'b1);
    push_exp(0, 1, 64'd1, 1'b0);
    push_exp(0, 2, 64'd2, 1'b0);
    step();
    set_valid(2'b01);
    @(negedge clk);
    total++;
    if (in_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_first_grant: got in_ready=%b, want 01", in_ready);
    end
    step(); step(); step();
    set_valid(2'b00);
    drain("single_hart");
  endtask

  task automatic test_burst();
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(0, i, 64'(i), i == 0);
    for (int i = 0; i < 4; i++) push_exp(1, i, 64'(4 + i), i == 0);
    push_exp(0, 0, 64'd8, 1'b1);
    set_valid(2'b11);
    for (int i = 0; i < 9; i++) step();
    set_valid(2'b00);
    drain("burst");
  endtask

  task automatic test_stall();
    logic [63:0] held_pc;
    push_exp(1, 0, 64'd9, 1'b1);
    held_pc = pc_of(1, exp_seq[1] - 1);
    set_valid(2'b10);
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_order !== 64'd9 || out_pc !== held_pc || out_hart !== 1'b1 || in_ready !== 2'b00) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got valid=%0b order=%0d pc=%h hart=%0d ready=%b, want 1 9 %h 1 00",
                 i, out_valid, out_order, out_pc, out_hart, in_ready, held_pc);
      end
      step();
    end
    push_exp(1, 1, 64'd10, 1'b0);
    out_ready = 1'b1;
    step();
    set_valid(2'b00);
    drain("stall");
  endtask

  task automatic test_order_load();
    push_exp(0, 0, 64'd100, 1'b1);
    push_exp(0, 1, 64'd101, 1'b0);
    set_valid(2'b01);
    order_load = 1'b1;
    order_init = 64'd100;
    step();
    order_load = 1'b0;
    step();
    set_valid(2'b00);
    order_load = 1'b1;
    order_init = '1;
    step();
    order_load = 1'b0;
    push_exp(0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_exp(0, 1, 64'd0, 1'b0);
    set_valid(2'b01);
    step(); step();
    set_valid(2'b00);
    drain("order_load");
  endtask

  task automatic test_handoff();
    push_exp(0, 0, 64'd1, 1'b0);
    set_valid(2'b01);
    step();
    push_exp(0, 1, 64'd2, 1'b0);
    set_valid(2'b11);
    @(negedge clk);
    total++;
    if (in_ready !== 2'b01) begin
      bad++;
      $display("FAIL handoff_owner_keep: got in_ready=%b, want 01", in_ready);
    end
    step();
    push_exp(1, 0, 64'd3, 1'b1);
    set_valid(2'b10);
    @(negedge clk);
    total++;
    if (in_ready !== 2'b10 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL handoff_switch: got in_ready=%b out_valid=%0b, want 10 1", in_ready, out_valid);
    end
    step();
    push_exp(1, 1, 64'd4, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_hart !== 1'b1) begin
      bad++;
      $display("FAIL handoff_no_bubble: got out_valid=%0b hart=%0d, want 1 1", out_valid, out_hart);
    end
    step();
    set_valid(2'b00);
    drain("handoff");
  endtask

  task automatic test_reset_mid();
    push_exp(1, 0, 64'd5, 1'b0);
    set_valid(2'b10);
    step();
    step();
    // Second hart-1 event is in the output register and gets dropped by reset.
    exp_seq[1]++;
    reset = 1'b1;
    set_valid(2'b00);
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_order !== 64'd0 || in_ready !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid_clear: got valid=%0b order=%0d ready=%b, want 0 0 00", out_valid, out_order, in_ready);
    end
    step();
    set_valid(2'b11);
    @(negedge clk);
    total++;
    if (in_ready !== 2'b01) begin
      bad++;
      $display("FAIL reset_mid_idle_grant: got in_ready=%b, want 01", in_ready);
    end
    push_exp(0, 0, 64'd0, 1'b1);
    step();
    set_valid(2'b00);
    drain("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    out_ready  = 1'b1;
    order_load = 1'b0;
    order_init = '0;
    valid_en   = 2'b00;
    seq[0] = 0; seq[1] = 0;
    exp_seq[0] = 0; exp_seq[1] = 0;
    apply_inputs();
    test_reset();
    test_single_hart();
    test_burst();
    test_stall();
    test_order_load();
    test_handoff();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvvi_retire_sequencer.md
Name: rvvi_retire_sequencer

Overview:
- Serialises retirement/trap events from NHART per-hart producers onto one RVVI event stream.
- Assigns the global ORDER value, the per-hart ISSUE slot and a HART-change marker, so a single trace writer or checker sees one ordered stream.
- Sits between the hart retirement ports and the RVVI trace/record back end.
- Arbitrates with a burst-limited round-robin scheme.

Parameters:
- NHART, 2, number of harts (≥1).
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- MAX_BURST, 4, max consecutive events granted to one hart before re-arbitration (≥1).
- ORDER_W, 64, order counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- in_valid  in  NHART  per-hart event valid.
- in_ready  out  NHART  per-hart accept.
- in_pc  in  NHART*XLEN  per-hart PC, hart h at [h*XLEN +: XLEN].
- in_insn  in  NHART*ILEN  per-hart instruction.
- in_trap  in  NHART  1 = TRAP event, 0 = RET event.
- order_load  in  1  load order counter.
- order_init  in  ORDER_W  value loaded by order_load.
- out_valid  out  1  output event valid.
- out_ready  in  1  downstream accept.
- out_hart  out  max(1,$clog2(NHART))  source hart.
- out_issue  out  max(1,$clog2(MAX_BURST))  issue slot within current burst.
- out_order  out  ORDER_W  global order of event.
- out_hart_switch  out  1  first event after a hart change, or first event after reset.
- out_pc  out  XLEN; out_insn  out  ILEN; out_trap  out  1  event payload.

Behaviour:
- Reset is synchronous and active-high; it takes effect on the clk rising edge.
  - Reset values: out_valid=0; all out_* payloads 0; order counter 0; state IDLE; burst count 0; last-granted hart = NHART-1, so hart 0 wins first; prev-emitted-hart invalid.
- Reset mid-operation: a held output event is dropped and all counters clear.
- Output is a single register stage.
  - slot_free = !out_valid || out_ready.
  - in_ready[h] = slot_free && grant[h]. At most one bit is set.
  - Transfer on input h when in_valid[h] && in_ready[h]. The event appears at the output the next cycle (1-cycle latency).
  - At full throughput one event is output per cycle.
- While out_valid && !out_ready, all out_* hold stable, every in_ready is 0, and no counters change.
- State machine, two states:
  - IDLE: grant goes to the first valid hart in round-robin order, starting at last_granted+1 modulo NHART. On a transfer, move to OWN(owner=h), burst=1, issue=0.
  - OWN: if in_valid[owner] && burst<MAX_BURST, grant owner. On transfer, issue=burst and burst++.
  - Leaving OWN: if the owner is not valid, or burst==MAX_BURST, perform a round-robin pick in the same cycle from owner+1. If a winner transfers, it becomes the new OWN with burst=1 and issue=0. If no hart is valid, go to IDLE.
  - A hart re-granted immediately after its own burst expired (it is the only valid hart) restarts at issue=0.
  - MAX_BURST=1 gives pure per-event round-robin.
- Order counter:
  - On each transfer, out_order is the current counter value, and the counter increments modulo 2^ORDER_W. It wraps from all-ones to 0 with no flag.
  - order_load with no transfer: counter = order_init.
  - order_load in the same cycle as a transfer: the event takes order_init and the counter becomes order_init+1.
- out_hart_switch = 1 when the captured hart ≠ prev-emitted-hart, or when prev is invalid.
  - prev-emitted-hart updates on every transfer.
- in_trap passes through unmodified. RET and TRAP are arbitrated identically.

Decomposition:
- Package rvvi_seq_pkg holds:
  - The event struct typedef {hart, issue, order, switch, pc, insn, trap}.
  - The width localparams derived from the parameters.
  - The state enum {IDLE, OWN}.
- One sub-module: rvvi_rr_arbiter.
  - Combinational rotate-priority pick of NHART requests from a start index.
  - Outputs a one-hot grant plus the encoded index.

Test Plan:
1. Hart 0 valid for 3 cycles, out_ready=1 → outputs on cycles 1–3 with order 0,1,2; issue 0,1,2; hart_switch 1,0,0.
2. Both harts continuously valid, MAX_BURST=4 → hart 0 gets issue 0..3, then hart 1 gets issue 0..3. hart_switch is 1 on order 0 and order 4. Orders are contiguous 0..7, then ownership returns to hart 0.
3. out_valid=1 with out_ready=0 for 5 cycles → payload stable, in_ready=0, counter unchanged. Releasing out_ready resumes with the next order value.
4. order_load=1, order_init=100 in the same cycle as a transfer → out_order=100, next event 101. Separately, order_init=2^64-1 → the next two events get 2^64-1 and 0.
5. Hart 0 drops valid after 2 events while hart 1 is valid → hart 1 is granted the next cycle with issue=0 and hart_switch=1, and there is no bubble.
6. reset while out_valid=1 and hart 1 is owner mid-burst → next cycle out_valid=0 and in_ready reflects IDLE. The first post-reset event comes from hart 0 with order 0 and hart_switch=1.
